// File: rtl/mult_pkg.sv
// Shared multiplier-datapath definitions: data width, destination select codes
// and the select-to-one-hot decoder used by the routing stages.
package mult_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned NUM_DEST = 6;
  localparam int unsigned SEL_W    = 3;

  localparam logic [SEL_W-1:0] SEL_A = 3'd0;
  localparam logic [SEL_W-1:0] SEL_B = 3'd1;
  localparam logic [SEL_W-1:0] SEL_C = 3'd2;
  localparam logic [SEL_W-1:0] SEL_D = 3'd3;
  localparam logic [SEL_W-1:0] SEL_E = 3'd4;
  localparam logic [SEL_W-1:0] SEL_F = 3'd5;

  // Select code to one-hot destination flag; codes 6 and 7 address nothing.
  function automatic logic [NUM_DEST-1:0] onehot3to6(input logic [SEL_W-1:0] sel);
    logic [NUM_DEST-1:0] oh;
    oh = '0;
    case (sel)
      SEL_A:   oh = 6'b000001;
      SEL_B:   oh = 6'b000010;
      SEL_C:   oh = 6'b000100;
      SEL_D:   oh = 6'b001000;
      SEL_E:   oh = 6'b010000;
      SEL_F:   oh = 6'b100000;
      default: oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/mux_one_to_six.sv
// Registered 1-to-6 routing stage of the multiplier datapath.
// Each rising edge of clock writes entrada to the output chosen by op and
// zero to all others; valid flags the loaded destination one-hot.
// Ports:
//   clock   - system clock, rising edge
//   reset   - synchronous active-high clear of all outputs
//   op      - destination select (0..5 -> a..f, 6/7 -> none)
//   entrada - data word to route
//   a..f    - registered destination words
//   valid   - registered one-hot of the destination loaded last edge
module mux_one_to_six
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH   = DATA_W,
  parameter int unsigned NUM_OUT = NUM_DEST
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [SEL_W-1:0]   op,
  input  logic [WIDTH-1:0]   entrada,
  output logic [WIDTH-1:0]   a,
  output logic [WIDTH-1:0]   b,
  output logic [WIDTH-1:0]   c,
  output logic [WIDTH-1:0]   d,
  output logic [WIDTH-1:0]   e,
  output logic [WIDTH-1:0]   f,
  output logic [NUM_OUT-1:0] valid
);

  logic [WIDTH-1:0]   out_d [NUM_OUT];
  logic [WIDTH-1:0]   out_q [NUM_OUT];
  logic [NUM_OUT-1:0] valid_d;
  logic [NUM_OUT-1:0] valid_q;

  // Next values: every destination is rewritten each edge, only the flagged one gets data.
  always_comb begin
    valid_d = onehot3to6(op);
    for (int unsigned i = 0; i < NUM_OUT; i++) begin
      out_d[i] = '0;
      if (valid_d[i]) begin
        out_d[i] = entrada;
      end
    end
  end

  // Output registers; reset overrides any routing request on the same edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < NUM_OUT; i++) begin
        out_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int unsigned i = 0; i < NUM_OUT; i++) begin
        out_q[i] <= out_d[i];
      end
    end
  end

  assign a     = out_q[0];
  assign b     = out_q[1];
  assign c     = out_q[2];
  assign d     = out_q[3];
  assign e     = out_q[4];
  assign f     = out_q[5];
  assign valid = valid_q;

endmodule

// File: tb/tb_mux_one_to_six.sv
// Self-checking bench for mux_one_to_six: directed cases followed by random
// traffic, compared against a reference model of the routing rules.
module tb_mux_one_to_six;

  logic        clock;
  logic        reset;
  logic [2:0]  op;
  logic [15:0] entrada;
  logic [15:0] a, b, c, d, e, f;
  logic [5:0]  valid;

  int unsigned n_cmp;
  int unsigned n_err;

  logic [15:0] exp_out [6];
  logic [5:0]  exp_valid;

  mux_one_to_six dut (
    .clock   (clock),
    .reset   (reset),
    .op      (op),
    .entrada (entrada),
    .a       (a),
    .b       (b),
    .c       (c),
    .d       (d),
    .e       (e),
    .f       (f),
    .valid   (valid)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Reference: after an edge, destination op holds the data, all else zero.
  task automatic model_edge(input logic rst, input logic [2:0] sel, input logic [15:0] data);
    for (int k = 0; k < 6; k++) exp_out[k] = 16'h0;
    exp_valid = 6'h0;
    if (!rst && sel <= 3'd5) begin
      exp_out[sel] = data;
      exp_valid    = 6'(1) << sel;
    end
  endtask

  task automatic check_all(input string tag);
    logic [15:0] got [6];
    got[0] = a; got[1] = b; got[2] = c; got[3] = d; got[4] = e; got[5] = f;
    for (int k = 0; k < 6; k++)
      check_eq($sformatf("%s_out%0d", tag, k), got[k], exp_out[k]);
    check_eq($sformatf("%s_valid", tag), 16'(valid), 16'(exp_valid));
  endtask

  // Apply inputs for one edge, check after it, then scramble inputs and
  // confirm the outputs stay put until the next edge.
  task automatic drive_edge(input logic rst, input logic [2:0] sel,
                            input logic [15:0] data, input string tag);
    @(negedge clock);
    reset   = rst;
    op      = sel;
    entrada = data;
    @(posedge clock);
    #1;
    model_edge(rst, sel, data);
    check_all(tag);
    op      = 3'($urandom_range(0, 7));
    entrada = 16'($urandom);
    #2;
    check_all($sformatf("%s_hold", tag));
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    clock   = 1'b0;
    reset   = 1'b1;
    op      = 3'd1;
    entrada = 16'hFFFF;

    drive_edge(1'b1, 3'd1, 16'hFFFF, "rst0");
    drive_edge(1'b1, 3'd1, 16'hFFFF, "rst1");

    drive_edge(1'b0, 3'd0, 16'd1, "sweep_a");
    drive_edge(1'b0, 3'd1, 16'd1, "sweep_b");
    drive_edge(1'b0, 3'd2, 16'd2, "sweep_c");
    drive_edge(1'b0, 3'd3, 16'd3, "sweep_d");
    drive_edge(1'b0, 3'd4, 16'd4, "sweep_e");
    drive_edge(1'b0, 3'd5, 16'd5, "sweep_f");

    drive_edge(1'b0, 3'd3, 16'd5, "resel_d");
    drive_edge(1'b0, 3'd0, 16'd8, "resel_a");

    drive_edge(1'b0, 3'd6, 16'h1234, "inv6");
    drive_edge(1'b0, 3'd7, 16'h1234, "inv7");

    drive_edge(1'b0, 3'd2, 16'd10, "track10");
    drive_edge(1'b0, 3'd2, 16'd20, "track20");
    drive_edge(1'b0, 3'd2, 16'd30, "track30");

    drive_edge(1'b0, 3'd0, 16'h0000, "zero_a");

    drive_edge(1'b0, 3'd4, 16'hABCD, "mid_e");
    drive_edge(1'b1, 3'd4, 16'hABCD, "mid_rst");
    drive_edge(1'b0, 3'd4, 16'hABCD, "mid_rel");

    for (int i = 0; i < 400; i++) begin
      drive_edge(($urandom_range(0, 15) == 0), 3'($urandom_range(0, 7)),
                 16'($urandom), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
